echo_mixer: RTL and testbench
=============================

ECHO_MIXER -- requirements
Module: echo_mixer

Interface
REQ-001 Parameter NUMBER_OF_BITS, default 8, sample width W (two's-complement signed).
REQ-002 Parameter SAMPLES_BUFFER_SIZE, default 10, ring-buffer depth D (D >= 2).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  a left/right sample pair from the I2S-to-PCM stage is present.
REQ-006 in_ready  output  1  block can accept a pair this cycle.
REQ-007 data_left  input  W  left PCM sample.
REQ-008 data_right  input  W  right PCM sample.
REQ-009 delay  input  $clog2(D)+1  echo delay in samples; sampled on acceptance.
REQ-010 data_output  output  W  mixed mono sample with echo.
REQ-011 out_valid  output  1  data_output is valid.
REQ-012 out_ready  input  1  downstream accepts data_output.
REQ-013 sat_flag  output  1  sticky; set when any result saturated.

Function
REQ-014 FSM states: IDLE, READ, MIX, OUTPUT; one state per cycle except OUTPUT.
REQ-015 IDLE: in_ready=1; on in_valid=1, capture data_left, data_right and delay; go to READ.
REQ-016 Non-IDLE states: in_ready=0; in_valid and input data ignored.
REQ-017 READ: mono = (data_left + data_right) >>> 1, computed on a W+1-bit signed sum and registered as W bits; echo sample read from the buffer at (wr_ptr - delay) mod D and registered.
REQ-018 Echo: delay = 0 gives echo = 0; delay >= D is clamped to D-1.
REQ-019 MIX: result = mono + (echo >>> 1), computed on W+1 bits, saturated to [-2^(W-1), 2^(W-1)-1], then registered to data_output.
REQ-020 MIX: sat_flag set if clipping occurred; mono written to buffer[wr_ptr]; wr_ptr advances, wrapping D-1 -> 0; next state OUTPUT.
REQ-021 OUTPUT: out_valid=1 and data_output held stable until out_ready=1; on that cycle, go to IDLE. out_valid is 0 in every other state.
REQ-022 Latency: pair accepted at cycle N gives out_valid=1 at cycle N+3, provided the block was in IDLE at cycle N.
REQ-023 Throughput: at most one pair per 4 cycles.
REQ-024 Echo reads only buffer entries written by earlier pairs, never the current pair. Entries not yet written since reset read as 0.
REQ-025 out_ready=1 while not in OUTPUT has no effect.

Reset
REQ-026 On reset assertion, immediately and independently of clk: state=IDLE, wr_ptr=0, every buffer entry=0, data_output=0, out_valid=0, sat_flag=0, captured registers=0.
REQ-027 After deassertion, in_ready=1 on the first clk edge.
REQ-028 Reset asserted mid-operation, including OUTPUT with a pending result, discards the in-flight sample without producing output.
REQ-029 sat_flag clears only on reset.

Verification
REQ-030 Reset: assert reset mid-clock -> outputs 0 at once, in_ready=1; then feed L=20, R=40, delay=0 -> data_output=30, out_valid at accept+3.
REQ-031 Echo: delay=3, feed mono 100, 0, 0, 0 (L=R) -> outputs 100, 0, 0, 50.
REQ-032 Saturation: delay=1, L=R=127 twice -> outputs 127, then 127 (190 clipped), sat_flag=1. With L=R=-128 twice after reset -> -128, -128, sat_flag=1.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles in OUTPUT while toggling in_valid -> data_output stable, in_ready=0, no pair accepted. Then out_ready=1 -> IDLE next cycle.
REQ-034 Wrap and clamp: feed 25 pairs of increasing mono values with delay=9, then delay=15 -> echo tracks the sample 9 back across the wr_ptr wrap, and delay=15 behaves as delay=9.
REQ-035 Reset in OUTPUT: assert reset while out_valid=1 -> out_valid=0 at once, the buffer reads back as zeros, and the next echo is 0.

Source files
------------

// File: rtl/echo_mixer.sv
// Stereo-to-mono mixer with a ring-buffer echo: each accepted L/R pair is averaged,
// combined with half of an earlier mono sample and saturated to W bits.
module echo_mixer #(
    parameter int unsigned NUMBER_OF_BITS      = 8,
    parameter int unsigned SAMPLES_BUFFER_SIZE = 10
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [NUMBER_OF_BITS-1:0]             data_left,
    input  logic [NUMBER_OF_BITS-1:0]             data_right,
    input  logic [$clog2(SAMPLES_BUFFER_SIZE):0]  delay,
    output logic [NUMBER_OF_BITS-1:0]             data_output,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  sat_flag
);

    localparam int unsigned W  = NUMBER_OF_BITS;
    localparam int unsigned D  = SAMPLES_BUFFER_SIZE;
    localparam int unsigned PW = $clog2(D);
    localparam int unsigned DW = PW + 1;

    localparam logic [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, READ, MIX, OUTPUT} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    left_q, left_d;
    logic [W-1:0]    right_q, right_d;
    logic [DW-1:0]   delay_q, delay_d;
    logic [W-1:0]    mono_q, mono_d;
    logic [W-1:0]    echo_q, echo_d;
    logic [W-1:0]    data_output_q, data_output_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;
    logic            sat_q, sat_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [W-1:0]    buf_q [D];
    logic [W-1:0]    buf_d [D];

    logic [W:0]      pair_sum;
    logic [W-1:0]    mono_new;
    logic [DW-1:0]   dly_eff;
    logic [PW:0]     rd_sum;
    logic [PW-1:0]   rd_idx;
    logic [W-1:0]    echo_rd;
    logic [W-1:0]    echo_half;
    logic [W:0]      mix_sum;
    logic            mix_ovf;
    logic [W-1:0]    mix_res;

    // Datapath: averaging, clamped echo lookup and saturating mix
    always_comb begin
        pair_sum  = {left_q[W-1], left_q} + {right_q[W-1], right_q};
        mono_new  = W'($signed(pair_sum) >>> 1);
        dly_eff   = (delay_q >= DW'(D)) ? DW'(D - 1) : delay_q;
        rd_sum    = (PW+1)'(wr_ptr_q) + (PW+1)'(D) - dly_eff;
        rd_idx    = (rd_sum >= (PW+1)'(D)) ? PW'(rd_sum - (PW+1)'(D)) : PW'(rd_sum);
        echo_rd   = (dly_eff == '0) ? '0 : buf_q[rd_idx];
        echo_half = W'($signed(echo_q) >>> 1);
        mix_sum   = {mono_q[W-1], mono_q} + {echo_half[W-1], echo_half};
        mix_ovf   = mix_sum[W] ^ mix_sum[W-1];
        mix_res   = mix_ovf ? (mix_sum[W] ? MIN_VAL : MAX_VAL) : mix_sum[W-1:0];
    end

    always_comb begin
        state_d       = state_q;
        left_d        = left_q;
        right_d       = right_q;
        delay_d       = delay_q;
        mono_d        = mono_q;
        echo_d        = echo_q;
        data_output_d = data_output_q;
        sat_d         = sat_q;
        wr_ptr_d      = wr_ptr_q;
        buf_d         = buf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    left_d  = data_left;
                    right_d = data_right;
                    delay_d = delay;
                    state_d = READ;
                end
            end
            READ: begin
                mono_d  = mono_new;
                echo_d  = echo_rd;
                state_d = MIX;
            end
            MIX: begin
                data_output_d    = mix_res;
                sat_d            = sat_q | mix_ovf;
                buf_d[wr_ptr_q]  = mono_q;
                wr_ptr_d         = (wr_ptr_q == PW'(D - 1)) ? '0 : wr_ptr_q + PW'(1);
                state_d          = OUTPUT;
            end
            OUTPUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Handshake flags follow the state being entered so they stay registered
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == OUTPUT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            left_q        <= '0;
            right_q       <= '0;
            delay_q       <= '0;
            mono_q        <= '0;
            echo_q        <= '0;
            data_output_q <= '0;
            out_valid_q   <= 1'b0;
            in_ready_q    <= 1'b1;
            sat_q         <= 1'b0;
            wr_ptr_q      <= '0;
            for (int unsigned i = 0; i < D; i++) buf_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            left_q        <= left_d;
            right_q       <= right_d;
            delay_q       <= delay_d;
            mono_q        <= mono_d;
            echo_q        <= echo_d;
            data_output_q <= data_output_d;
            out_valid_q   <= out_valid_d;
            in_ready_q    <= in_ready_d;
            sat_q         <= sat_d;
            wr_ptr_q      <= wr_ptr_d;
            buf_q         <= buf_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign data_output = data_output_q;
    assign sat_flag    = sat_q;

endmodule

// File: tb/tb_echo_mixer.sv
// Self-checking bench for echo_mixer: directed vector table, hand-written corner
// sequences and randomized pairs checked against a sample-history reference model.
module tb_echo_mixer;

    localparam int W = 8;
    localparam int D = 10;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] data_left = '0;
    logic [W-1:0] data_right = '0;
    logic [4:0]   delay = '0;
    logic [W-1:0] data_output;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         sat_flag;

    int n_chk  = 0;
    int n_pass = 0;

    int hist[$];
    bit m_sat = 1'b0;

    typedef struct {
        bit rst;
        int l;
        int r;
        int dly;
        int exp;
        bit sat;
    } vec_t;

    vec_t tbl[10];

    echo_mixer #(.NUMBER_OF_BITS(W), .SAMPLES_BUFFER_SIZE(D)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .data_left(data_left), .data_right(data_right), .delay(delay),
        .data_output(data_output), .out_valid(out_valid), .out_ready(out_ready),
        .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic int dout();
        return int'($signed(data_output));
    endfunction

    // Reference: mono is the floored average; echo is the mono value d pairs ago
    function automatic int model_pair(input int l, input int r, input int dly);
        int mono, d, echo, res;
        mono = (l + r) >>> 1;
        d    = (dly >= D) ? D - 1 : dly;
        echo = (d == 0 || hist.size() < d) ? 0 : hist[hist.size() - d];
        res  = mono + (echo >>> 1);
        if (res > 127)  begin res = 127;  m_sat = 1'b1; end
        if (res < -128) begin res = -128; m_sat = 1'b1; end
        hist.push_back(mono);
        return res;
    endfunction

    task automatic model_clear();
        hist.delete();
        m_sat = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_data_output"}, dout(), 0);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_sat_flag"}, int'(sat_flag), 0);
    endtask

    // Reset asserted mid-cycle; outputs must clear without a clock edge
    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic do_pair(input int l, input int r, input int dly, input int exp,
                           input bit exp_sat, input int hold, input bit early,
                           input bit abort);
        int w;
        w = 0;
        while (!in_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_idle", int'(in_ready), 1);
        in_valid   = 1'b1;
        data_left  = l[W-1:0];
        data_right = r[W-1:0];
        delay      = dly[4:0];
        out_ready  = early ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        in_valid   = 1'b0;
        data_left  = W'($urandom());
        data_right = W'($urandom());
        delay      = 5'($urandom());
        chk("lat1_out_valid", int'(out_valid), 0);
        chk("lat1_in_ready", int'(in_ready), 0);
        @(negedge clk);
        chk("lat2_out_valid", int'(out_valid), 0);
        out_ready = early ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        chk("lat3_out_valid", int'(out_valid), 1);
        chk("data_output", dout(), exp);
        chk("sat_flag", int'(sat_flag), int'(exp_sat));
        if (abort) begin
            #2 reset = 1'b1;
            #1 check_reset_outputs("reset_in_output");
            @(negedge clk);
            reset = 1'b0;
            model_clear();
            return;
        end
        for (int i = 0; i < hold; i++) begin
            in_valid   = i[0];
            data_left  = W'($urandom());
            data_right = W'($urandom());
            @(negedge clk);
            chk("hold_out_valid", int'(out_valid), 1);
            chk("hold_data_output", dout(), exp);
            chk("hold_in_ready", int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_out_valid", int'(out_valid), 0);
        chk("release_in_ready", int'(in_ready), 1);
    endtask

    task automatic model_run(input int l, input int r, input int dly, input int hold,
                             input bit early);
        int e;
        e = model_pair(l, r, dly);
        do_pair(l, r, dly, e, m_sat, hold, early, 1'b0);
    endtask

    initial begin
        tbl[0] = '{1'b1,   20,   40, 0,   30, 1'b0};
        tbl[1] = '{1'b1,  100,  100, 3,  100, 1'b0};
        tbl[2] = '{1'b0,    0,    0, 3,    0, 1'b0};
        tbl[3] = '{1'b0,    0,    0, 3,    0, 1'b0};
        tbl[4] = '{1'b0,    0,    0, 3,   50, 1'b0};
        tbl[5] = '{1'b1,  127,  127, 1,  127, 1'b0};
        tbl[6] = '{1'b0,  127,  127, 1,  127, 1'b1};
        tbl[7] = '{1'b1, -128, -128, 1, -128, 1'b0};
        tbl[8] = '{1'b0, -128, -128, 1, -128, 1'b1};
        tbl[9] = '{1'b0, -100,  -60, 0,  -80, 1'b1};

        @(negedge clk);
        check_reset_outputs("power_on_reset");
        reset = 1'b0;

        // Interrupted transaction first, then the table (row 0 follows a mid-clock reset)
        do_pair(10, 10, 0, 10, 1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].rst) do_reset();
            do_pair(tbl[i].l, tbl[i].r, tbl[i].dly, tbl[i].exp, tbl[i].sat, 0, 1'b0, 1'b0);
        end

        // Backpressure: garbage offered while stalled must not enter the history
        do_reset();
        do_pair(30, 50, 0, 40, 1'b0, 5, 1'b0, 1'b0);
        do_pair(10, 10, 1, 30, 1'b0, 0, 1'b0, 1'b0);

        // Reset while a result is pending clears the buffer
        do_reset();
        do_pair(80, 80, 1, 80, 1'b0, 0, 1'b0, 1'b0);
        do_pair(60, 60, 1, 100, 1'b0, 2, 1'b0, 1'b1);
        do_pair(0, 0, 1, 0, 1'b0, 0, 1'b0, 1'b0);
        do_pair(0, 0, 9, 0, 1'b0, 0, 1'b0, 1'b0);

        // Pointer wrap with delay 9, then the out-of-range delay 15
        do_reset();
        for (int k = 1; k <= 25; k++) model_run(2 * k, 2 * k, 9, 0, 1'b0);
        for (int k = 26; k <= 31; k++) model_run(2 * k, 2 * k, 15, 0, 1'b0);

        // Randomized pairs, delays, stalls and early out_ready
        do_reset();
        for (int n = 0; n < 60; n++) begin
            int l, r, dly, hold;
            bit early;
            l     = int'($urandom_range(0, 255)) - 128;
            r     = int'($urandom_range(0, 255)) - 128;
            dly   = int'($urandom_range(0, 15));
            hold  = int'($urandom_range(0, 3));
            early = 1'($urandom_range(0, 1));
            model_run(l, r, dly, hold, early);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
